data_mem_responder: RTL and testbench

Data-memory responder for the pipelined RISC-V core: the slave end of the core's data-memory interface. Accepts one load/store request at a time over a valid/ready handshake, applies programmable wait states, and performs byte/half/word writes with lane enables derived from the store type. Returns the aligned 32-bit word with a one-response handshake. Detects misaligned and out-of-range accesses. Load sign/zero extension and lane extraction stay in the core's writeback stage.

---
 rtl/data_mem_responder.sv | 151 +++++++++++++++
 tb/tb_data_mem_responder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder: slave end of the core's load/store port with programmable
// wait states, byte/half/word store lanes and misaligned/out-of-range detection.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_store_type,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0] DEPTH_W   = 30'(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_LOAD = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic        accept_c, access_c;

  logic        lat_we;
  logic [31:0] lat_addr, lat_wdata;
  logic [1:0]  lat_st;

  logic        acc_we_c;
  logic [31:0] acc_addr_c, acc_wdata_c;
  logic [1:0]  acc_st_c;
  logic        err_c, oor_c, mis_c, rsv_c;
  logic [3:0]  be_c;
  logic [31:0] wd_c;
  logic [AW-1:0] idx_c;

  logic [31:0] mem [DEPTH_WORDS];

  // Next-state, counter and strobe decode
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept_c   = 1'b0;
    access_c   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept_c = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_next = RESP;
            access_c   = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_next = RESP;
          access_c   = 1'b1;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // With zero wait states the access happens on the accept edge, so use the live request
  always_comb begin
    acc_we_c    = (state == IDLE) ? req_we         : lat_we;
    acc_addr_c  = (state == IDLE) ? req_addr       : lat_addr;
    acc_wdata_c = (state == IDLE) ? req_wdata      : lat_wdata;
    acc_st_c    = (state == IDLE) ? req_store_type : lat_st;
    idx_c       = acc_addr_c[AW+1:2];
    oor_c       = (acc_addr_c[31:2] >= DEPTH_W);
    mis_c       = ((acc_st_c == 2'b01) && acc_addr_c[0]) ||
                  ((acc_st_c == 2'b10) && (acc_addr_c[1:0] != 2'b00));
    rsv_c       = (acc_st_c == 2'b11);
    err_c       = oor_c || (acc_we_c && (mis_c || rsv_c));
    be_c        = 4'b0000;
    wd_c        = acc_wdata_c;
    case (acc_st_c)
      2'b00: begin
        be_c = 4'b0001 << acc_addr_c[1:0];
        wd_c = {4{acc_wdata_c[7:0]}};
      end
      2'b01: begin
        be_c = acc_addr_c[1] ? 4'b1100 : 4'b0011;
        wd_c = {2{acc_wdata_c[15:0]}};
      end
      2'b10:   be_c = 4'b1111;
      default: be_c = 4'b0000;
    endcase
  end

  // Control, latched request and registered response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      lat_we    <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      lat_st    <= 2'b00;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      req_ready <= (state_next == IDLE);
      rsp_valid <= (state_next == RESP);
      if (accept_c) begin
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_st    <= req_store_type;
      end
      if (access_c) begin
        rsp_rdata <= (!acc_we_c && !err_c) ? mem[idx_c] : 32'd0;
        rsp_err   <= err_c;
      end
    end
  end

  // Storage array is deliberately not reset
  always_ff @(posedge clk) begin
    if (access_c && acc_we_c && !err_c) begin
      for (int k = 0; k < 4; k++) begin
        if (be_c[k]) mem[idx_c][8*k +: 8] <= wd_c[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a zero-wait and a three-wait instance checked
// against a byte-addressed memory model with directed and random transactions.
module tb_data_mem_responder;

  localparam int unsigned DEPTH = 1024;

  logic        clk;
  logic        rst        [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [1:0]  req_st     [2];
  logic        rsp_valid  [2];
  logic        rsp_ready  [2];
  logic [31:0] rsp_rdata  [2];
  logic        rsp_err    [2];

  int          waits [2] = '{0, 3};
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_rdata;
  logic        last_err;
  logic [7:0]  mb [longint];

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_store_type(req_st[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_store_type(req_st[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic longint key(input int d, input logic [31:0] a);
    return longint'({31'd0, d[0], a});
  endfunction

  // Memory seen as little-endian bytes; a store of 2^st bytes must be naturally aligned
  task automatic model(input int d, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] st,
                       output logic [31:0] er, output logic ee);
    int size;
    longint base;
    er   = 32'd0;
    ee   = 1'b0;
    size = 1 << st;
    if ((addr >> 2) >= DEPTH) ee = 1'b1;
    if (we && (st == 2'b11 || (addr & 32'(size - 1)) != 0)) ee = 1'b1;
    if (!ee) begin
      if (we) begin
        for (int i = 0; i < size; i++) mb[key(d, addr) + longint'(i)] = wdata[8*i +: 8];
      end else begin
        base = key(d, addr & 32'hFFFF_FFFC);
        for (int i = 0; i < 4; i++)
          er[8*i +: 8] = mb.exists(base + longint'(i)) ? mb[base + longint'(i)] : 8'h00;
      end
    end
  endtask

  task automatic txn(input int d, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [1:0] st, input int hold);
    logic [31:0] er;
    logic        ee;
    int          lat;
    model(d, we, addr, wdata, st, er, ee);
    check("idle_req_ready", 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_st[d]    = st;
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    lat = 0;
    while (rsp_valid[d] !== 1'b1 && lat < 40) begin
      check("wait_req_ready", 32'(req_ready[d]), 32'd0);
      @(posedge clk);
      #1;
      lat++;
    end
    check("rsp_latency", 32'(lat), 32'(waits[d]));
    check("rsp_err", 32'(rsp_err[d]), 32'(ee));
    check("rsp_rdata", rsp_rdata[d], er);
    last_rdata = rsp_rdata[d];
    last_err   = rsp_err[d];
    repeat (hold) begin
      @(posedge clk);
      #1;
      check("hold_valid", 32'(rsp_valid[d]), 32'd1);
      check("hold_rdata", rsp_rdata[d], er);
      check("hold_req_ready", 32'(req_ready[d]), 32'd0);
    end
    rsp_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[d] = 1'b0;
    check("post_rsp_valid", 32'(rsp_valid[d]), 32'd0);
    check("post_req_ready", 32'(req_ready[d]), 32'd1);
  endtask

  task automatic check_reset_outputs(input int d);
    check("rst_req_ready", 32'(req_ready[d]), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
    check("rst_rsp_rdata", rsp_rdata[d], 32'd0);
    check("rst_rsp_err", 32'(rsp_err[d]), 32'd0);
  endtask

  initial begin
    logic        rwe;
    logic [31:0] raddr;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b0; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = 32'd0;
      req_wdata[d] = 32'd0; req_st[d] = 2'b00; rsp_ready[d] = 1'b0;
    end
    #12;
    check_reset_outputs(0);
    check_reset_outputs(1);
    @(posedge clk);
    #1;
    rst[0] = 1'b1;
    rst[1] = 1'b1;

    // Zero-wait instance: word, byte, half, error cases
    txn(0, 1'b1, 32'h40, 32'hDEAD_BEEF, 2'b10, 0);
    check("sw_rdata_zero", last_rdata, 32'd0);
    txn(0, 1'b0, 32'h40, 32'd0, 2'b00, 0);
    check("lw_40", last_rdata, 32'hDEAD_BEEF);
    txn(0, 1'b1, 32'h04, 32'h1122_3344, 2'b10, 0);
    txn(0, 1'b1, 32'h06, 32'h0000_00AB, 2'b00, 0);
    txn(0, 1'b0, 32'h04, 32'd0, 2'b00, 0);
    check("lw_after_sb", last_rdata, 32'h11AB_3344);
    txn(0, 1'b1, 32'h04, 32'h0000_CAFE, 2'b01, 0);
    txn(0, 1'b0, 32'h04, 32'd0, 2'b00, 0);
    check("lw_after_sh", last_rdata, 32'h11AB_CAFE);
    txn(0, 1'b1, 32'h42, 32'h5555_5555, 2'b10, 0);
    check("sw_mis_err", 32'(last_err), 32'd1);
    check("sw_mis_rdata", last_rdata, 32'd0);
    txn(0, 1'b0, 32'h40, 32'd0, 2'b00, 0);
    check("lw_40_unchanged", last_rdata, 32'hDEAD_BEEF);
    txn(0, 1'b1, 32'h41, 32'h0000_7777, 2'b01, 0);
    check("sh_mis_err", 32'(last_err), 32'd1);
    txn(0, 1'b1, 32'h48, 32'h1234_5678, 2'b11, 0);
    check("reserved_err", 32'(last_err), 32'd1);
    txn(0, 1'b0, 32'h1000, 32'd0, 2'b00, 0);
    check("lw_oor_err", 32'(last_err), 32'd1);
    check("lw_oor_rdata", last_rdata, 32'd0);
    txn(0, 1'b1, 32'h00, 32'h0BAD_F00D, 2'b10, 0);
    txn(0, 1'b1, 32'h1000, 32'hFFFF_FFFF, 2'b10, 0);
    check("sw_oor_err", 32'(last_err), 32'd1);
    txn(0, 1'b0, 32'h00, 32'd0, 2'b00, 0);
    check("lw_0_unchanged", last_rdata, 32'h0BAD_F00D);

    // Three-wait instance: latency and backpressure
    txn(1, 1'b1, 32'h80, 32'hA5A5_A5A5, 2'b10, 0);
    txn(1, 1'b0, 32'h80, 32'd0, 2'b00, 5);
    check("w3_lw_80", last_rdata, 32'hA5A5_A5A5);

    // Reset one cycle into WAIT drops the store
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h80;
    req_wdata[1] = 32'h1234_5678; req_st[1] = 2'b10;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    @(posedge clk);
    #1;
    rst[1] = 1'b0;
    #1;
    check_reset_outputs(1);
    repeat (2) @(posedge clk);
    #1;
    rst[1] = 1'b1;
    txn(1, 1'b0, 32'h80, 32'd0, 2'b00, 0);
    check("w3_lw_80_after_rst", last_rdata, 32'hA5A5_A5A5);

    // Random traffic over a preloaded window plus some out-of-range addresses
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 16; w++) txn(d, 1'b1, 32'(w * 4), $urandom, 2'b10, 0);
      for (int n = 0; n < 40; n++) begin
        rwe   = 1'($urandom_range(0, 1));
        raddr = ($urandom_range(0, 7) == 0) ? 32'h1000 + 32'($urandom_range(0, 63))
                                            : 32'($urandom_range(0, 63));
        txn(d, rwe, raddr, $urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 2));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
